// File: rtl/ps2_key_decoder.sv
// Turns PS/2 scan code set 2 bytes into held-key levels and drop pulses for two players.
// Latency: 1 cycle from byte_valid to registered outputs; no backpressure, every strobe is consumed.
module ps2_key_decoder #(
   parameter int TIMEOUT_CYCLES = 2_500_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   input  logic       release_all,
   output logic       j1_up,
   output logic       j1_down,
   output logic       j1_left,
   output logic       j1_right,
   output logic       j1_drop,
   output logic       j2_up,
   output logic       j2_down,
   output logic       j2_left,
   output logic       j2_right,
   output logic       j2_drop,
   output logic       j1_drop_pulse,
   output logic       j2_drop_pulse
);
   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   // Reaching TIMEOUT_CYCLES-1 abandons the prefix, so the last live count is TIMEOUT_CYCLES-2.
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 2);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXT     = 2'd1,
      BRK     = 2'd2,
      EXT_BRK = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [9:0]    keys_q, keys_d;
   logic [1:0]    pulse_q, pulse_d;
   logic          is_ext, is_brk;
   logic [9:0]    key_mask;

   assign is_ext = (state_q == EXT) || (state_q == EXT_BRK);
   assign is_brk = (state_q == BRK) || (state_q == EXT_BRK);

   // Key bit order: j1 up/down/left/right/drop, then j2 up/down/left/right/drop.
   always_comb begin
      key_mask = '0;
      if (is_ext) begin
         case (byte_in)
            8'h75:   key_mask[5] = 1'b1;
            8'h72:   key_mask[6] = 1'b1;
            8'h6B:   key_mask[7] = 1'b1;
            8'h74:   key_mask[8] = 1'b1;
            default: ;
         endcase
      end else begin
         case (byte_in)
            8'h1D:   key_mask[0] = 1'b1;
            8'h1B:   key_mask[1] = 1'b1;
            8'h1C:   key_mask[2] = 1'b1;
            8'h23:   key_mask[3] = 1'b1;
            8'h29:   key_mask[4] = 1'b1;
            8'h5A:   key_mask[9] = 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      keys_d  = keys_q;
      pulse_d = 2'b00;
      if (release_all) begin
         state_d = IDLE;
         cnt_d   = '0;
         keys_d  = '0;
      end else if (byte_valid) begin
         cnt_d = '0;
         if (byte_in == 8'hE0) begin
            state_d = EXT;
         end else if (byte_in == 8'hF0) begin
            case (state_q)
               IDLE:    state_d = BRK;
               EXT:     state_d = EXT_BRK;
               default: state_d = state_q;
            endcase
         end else begin
            state_d = IDLE;
            if (is_brk) begin
               keys_d = keys_q & ~key_mask;
            end else begin
               keys_d     = keys_q | key_mask;
               pulse_d[0] = key_mask[4] & ~keys_q[4];
               pulse_d[1] = key_mask[9] & ~keys_q[9];
            end
         end
      end else if (state_q != IDLE) begin
         if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         keys_q  <= '0;
         pulse_q <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         keys_q  <= keys_d;
         pulse_q <= pulse_d;
      end
   end

   assign j1_up         = keys_q[0];
   assign j1_down       = keys_q[1];
   assign j1_left       = keys_q[2];
   assign j1_right      = keys_q[3];
   assign j1_drop       = keys_q[4];
   assign j2_up         = keys_q[5];
   assign j2_down       = keys_q[6];
   assign j2_left       = keys_q[7];
   assign j2_right      = keys_q[8];
   assign j2_drop       = keys_q[9];
   assign j1_drop_pulse = pulse_q[0];
   assign j2_drop_pulse = pulse_q[1];
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized and directed bench for ps2_key_decoder against a table-driven reference model.
module tb_ps2_key_decoder;
   localparam int T = 8;

   logic       clk = 1'b0;
   logic       reset, byte_valid, release_all;
   logic [7:0] byte_in;
   logic j1_up, j1_down, j1_left, j1_right, j1_drop;
   logic j2_up, j2_down, j2_left, j2_right, j2_drop;
   logic j1_drop_pulse, j2_drop_pulse;

   int n_checks = 0;
   int n_fail   = 0;

   ps2_key_decoder #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
      .release_all(release_all),
      .j1_up(j1_up), .j1_down(j1_down), .j1_left(j1_left), .j1_right(j1_right),
      .j1_drop(j1_drop),
      .j2_up(j2_up), .j2_down(j2_down), .j2_left(j2_left), .j2_right(j2_right),
      .j2_drop(j2_drop),
      .j1_drop_pulse(j1_drop_pulse), .j2_drop_pulse(j2_drop_pulse)
   );

   always #5 clk = ~clk;

   // Key table: index order is j1 up,down,left,right,drop then j2 up,down,left,right,drop.
   logic [7:0] key_code [10] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29,
                                 8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A};
   bit         key_ext  [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
   logic [7:0] junk     [7]  = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1};

   // Reference model: pending prefix flags plus the cycle the last byte of it arrived.
   bit [9:0] m_keys;
   bit [1:0] m_pulse;
   bit       m_pend, m_ext, m_brk;
   int       m_pcyc;
   int       cyc = 0;

   function automatic int lookup(bit ext, logic [7:0] b);
      for (int i = 0; i < 10; i++)
         if (key_code[i] == b && key_ext[i] == ext) return i;
      return -1;
   endfunction

   task automatic model_step(input bit r, input bit rel, input bit v, input logic [7:0] b);
      int idx;
      m_pulse = 2'b00;
      if (r || rel) begin
         m_keys = '0;
         m_pend = 0; m_ext = 0; m_brk = 0;
         return;
      end
      if (m_pend && (cyc - m_pcyc) > T - 1) begin
         m_pend = 0; m_ext = 0; m_brk = 0;
      end
      if (!v) return;
      if (b == 8'hE0) begin
         m_pend = 1; m_ext = 1; m_brk = 0; m_pcyc = cyc;
      end else if (b == 8'hF0) begin
         m_pend = 1; m_brk = 1; m_pcyc = cyc;
      end else begin
         idx = lookup(m_ext, b);
         if (idx >= 0) begin
            if (m_brk) m_keys[idx] = 1'b0;
            else begin
               if (idx == 4 && !m_keys[4]) m_pulse[0] = 1'b1;
               if (idx == 9 && !m_keys[9]) m_pulse[1] = 1'b1;
               m_keys[idx] = 1'b1;
            end
         end
         m_pend = 0; m_ext = 0; m_brk = 0;
      end
   endtask

   function automatic logic [11:0] outs();
      return {j2_drop_pulse, j1_drop_pulse, j2_drop, j2_right, j2_left, j2_down, j2_up,
              j1_drop, j1_right, j1_left, j1_down, j1_up};
   endfunction

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: outputs=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive one cycle at the falling edge, advance the model, then compare after the next edge.
   task automatic step(input bit r, input bit rel, input bit v, input logic [7:0] b);
      reset       = r;
      release_all = rel;
      byte_valid  = v;
      byte_in     = v ? b : 8'($urandom);
      model_step(r, rel, v, b);
      @(negedge clk);
      cyc++;
      check("model", outs(), {m_pulse, m_keys});
   endtask

   task automatic send(input logic [7:0] b);
      step(0, 0, 1, b);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00);
   endtask

   function automatic logic [7:0] rand_byte();
      case ($urandom_range(0, 9))
         0, 1, 2, 3: return key_code[$urandom_range(0, 9)];
         4:          return 8'hE0;
         5:          return 8'hF0;
         6, 7:       return junk[$urandom_range(0, 6)];
         default:    return 8'($urandom);
      endcase
   endfunction

   initial begin
      logic [11:0] saved;
      int pct [4] = '{70, 30, 10, 50};
      reset = 1'b1; release_all = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
      m_keys = '0; m_pulse = '0; m_pend = 0; m_ext = 0; m_brk = 0; m_pcyc = 0;
      @(negedge clk);

      step(1, 0, 0, 8'h00);
      check("reset", outs(), 12'h000);

      send(8'h1D);                  check("make_w", outs(), 12'h001);
      send(8'hF0); send(8'h1D);     check("break_w", outs(), 12'h000);
      send(8'hE0); send(8'h75);     check("ext_up", outs(), 12'h020);
      send(8'hE0); send(8'hF0); send(8'h75);
      check("ext_break_up", outs(), 12'h000);
      send(8'h75);                  check("keypad_ignored", outs(), 12'h000);

      send(8'h29);                  check("drop_pulse", outs(), 12'h410);
      send(8'h29);                  check("typematic_1", outs(), 12'h010);
      send(8'h29);                  check("typematic_2", outs(), 12'h010);
      send(8'hF0); send(8'h29);     check("drop_break", outs(), 12'h000);
      send(8'h29);                  check("drop_pulse_2", outs(), 12'h410);
      send(8'hF0); send(8'h29);

      send(8'hF0); idle(7); send(8'h1D);
      check("timeout_make", outs(), 12'h001);
      send(8'hF0); idle(5); send(8'h1D);
      check("in_time_break", outs(), 12'h000);
      send(8'h1D);
      send(8'hF0); idle(6); send(8'h1D);
      check("boundary_break", outs(), 12'h000);

      send(8'hF0); step(1, 0, 0, 8'h00); send(8'h1D);
      check("reset_abandons", outs(), 12'h001);

      send(8'h23); send(8'h5A);     check("held_three", outs(), 12'hA09);
      step(0, 1, 1, 8'h1C);         check("release_all", outs(), 12'h000);
      send(8'h1B);                  check("after_release", outs(), 12'h002);

      send(8'hE0); send(8'h6B);     check("j2_left", outs(), 12'h082);
      send(8'hE0); send(8'hF0); send(8'h6B);
      check("b2b_break", outs(), 12'h002);
      saved = outs();
      send(8'hAA); send(8'hFA);     check("junk_nochange", outs(), saved);
      send(8'hE0); send(8'h5A);     check("kp_enter", outs(), 12'h002);

      for (int ph = 0; ph < 4; ph++) begin
         for (int i = 0; i < 1000; i++) begin
            bit r, rel, v;
            r   = ($urandom_range(0, 255) == 0);
            rel = ($urandom_range(0, 63) == 0);
            v   = ($urandom_range(0, 99) < pct[ph]);
            step(r, rel, v, rand_byte());
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
